// File: rtl/seg_scan_scheduler.sv
// Multiplexed seven-segment scan controller: single-clock slot prescaler, rotating
// active-low anodes with a blanking gap, and a one-deep frame buffer swapped at frame wrap.
module seg_scan_scheduler #(
  parameter int DIGITS       = 4,
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   frame_data,
  input  logic [DIGITS-1:0]     frame_dp,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  output logic                  frame_done,
  output logic [DIGITS-1:0]     an,
  output logic [3:0]            hex,
  output logic                  dp
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_shadow_data;
  logic [DIGITS-1:0]   r_shadow_dp;
  logic [4*DIGITS-1:0] r_pend_data;
  logic [DIGITS-1:0]   r_pend_dp;
  logic                r_pend_full;
  logic                r_ready;
  logic                r_done;
  logic [DIGITS-1:0]   r_an;
  logic [3:0]          r_hex;
  logic                r_dp;

  logic                w_last_cnt;
  logic                w_wrap;
  logic                w_xfer;
  logic                w_swap;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [4*DIGITS-1:0] w_shadow_data_nxt;
  logic [DIGITS-1:0]   w_shadow_dp_nxt;
  logic                w_pend_full_nxt;
  logic                w_blank_nxt;
  logic                w_done_nxt;
  logic [DIGITS-1:0]   w_an_nxt;
  logic [3:0]          w_hex_nxt;
  logic                w_dp_nxt;

  always_comb begin
    w_last_cnt = (r_cnt == CNT_LAST);
    w_wrap     = w_last_cnt && (r_idx == IDX_LAST);
    w_xfer     = frame_valid && r_ready;
    w_swap     = w_wrap && r_pend_full;

    w_cnt_nxt = w_last_cnt ? '0 : r_cnt + CNT_W'(1);
    w_idx_nxt = r_idx;
    if (w_last_cnt) w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);

    // A frame captured on the wrap cycle lands in pending, never directly in shadow.
    w_shadow_data_nxt = w_swap ? r_pend_data : r_shadow_data;
    w_shadow_dp_nxt   = w_swap ? r_pend_dp   : r_shadow_dp;
    w_pend_full_nxt   = w_xfer || (r_pend_full && !w_swap);

    w_done_nxt  = (w_cnt_nxt == CNT_LAST) && (w_idx_nxt == IDX_LAST);
    w_blank_nxt = (int'(w_cnt_nxt) < BLANK_CYCLES);

    // Pins are decoded from next-state so they line up with cnt/idx of the same cycle.
    w_an_nxt  = '1;
    w_hex_nxt = '0;
    w_dp_nxt  = 1'b1;
    if (!w_blank_nxt) begin
      w_an_nxt  = ~(DIGITS'(1) << w_idx_nxt);
      w_hex_nxt = 4'(w_shadow_data_nxt >> (4 * int'(w_idx_nxt)));
      w_dp_nxt  = ~w_shadow_dp_nxt[w_idx_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_shadow_data <= '0;
      r_shadow_dp   <= '0;
      r_pend_data   <= '0;
      r_pend_dp     <= '0;
      r_pend_full   <= 1'b0;
      r_ready       <= 1'b0;
      r_done        <= 1'b0;
      r_an          <= '1;
      r_hex         <= '0;
      r_dp          <= 1'b1;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_idx         <= w_idx_nxt;
      r_shadow_data <= w_shadow_data_nxt;
      r_shadow_dp   <= w_shadow_dp_nxt;
      if (w_xfer) begin
        r_pend_data <= frame_data;
        r_pend_dp   <= frame_dp;
      end
      r_pend_full   <= w_pend_full_nxt;
      r_ready       <= !w_pend_full_nxt;
      r_done        <= w_done_nxt;
      r_an          <= w_an_nxt;
      r_hex         <= w_hex_nxt;
      r_dp          <= w_dp_nxt;
    end
  end

  assign frame_ready = r_ready;
  assign frame_done  = r_done;
  assign an          = r_an;
  assign hex         = r_hex;
  assign dp          = r_dp;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Scoreboard bench for seg_scan_scheduler: a cycle-count based model pushes the expected
// pins after each edge; they are popped and compared on the following falling edge.
module tb_seg_scan_scheduler;

  localparam int DIGITS = 4;
  localparam int TDIV   = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS * TDIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] frame_data = '0;
  logic [3:0]  frame_dp = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic        frame_done;
  logic [3:0]  an;
  logic [3:0]  hex;
  logic        dp;

  seg_scan_scheduler #(.DIGITS(DIGITS), .TICK_DIV(TDIV), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst(rst), .frame_data(frame_data), .frame_dp(frame_dp),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_done(frame_done),
    .an(an), .hex(hex), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] hex;
    logic       dp;
    logic       rdy;
    logic       done;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Model state, indexed by m_t = cycles since the last reset edge.
  int          m_t = 0;
  logic        m_pend_full = 1'b0;
  logic [15:0] m_pend_data = '0;
  logic [3:0]  m_pend_dp = '0;
  logic [15:0] m_sh_data = '0;
  logic [3:0]  m_sh_dp = '0;
  logic        m_rdy = 1'b0;
  logic        m_xfer = 1'b0;
  logic        did_rst = 1'b0;
  int          low_cnt [DIGITS];
  int          last_done_t = -1;
  int          done_seen = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0d: got %0h expected %0h", tag, m_t, act, exp);
    end
  endtask

  function automatic exp_t model_pins();
    logic [3:0] an_tbl [DIGITS];
    exp_t e;
    int cnt, idx;
    an_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    cnt = m_t % TDIV;
    idx = (m_t / TDIV) % DIGITS;
    e.rdy  = m_rdy;
    e.done = ((m_t % FRAME) == FRAME - 1);
    if (cnt < BLANK) begin
      e.an = 4'b1111; e.hex = 4'h0; e.dp = 1'b1;
    end else begin
      e.an  = an_tbl[idx];
      e.hex = 4'((m_sh_data >> (4 * idx)) & 16'hF);
      e.dp  = ~m_sh_dp[idx];
    end
    return e;
  endfunction

  task automatic step();
    exp_t e;
    logic wrap;
    @(posedge clk);
    if (rst) begin
      m_t = 0; m_pend_full = 1'b0; m_sh_data = '0; m_sh_dp = '0;
      m_rdy = 1'b0; m_xfer = 1'b0;
    end else begin
      wrap   = ((m_t % FRAME) == FRAME - 1);
      m_xfer = frame_valid && m_rdy;
      if (wrap && m_pend_full) begin
        m_sh_data = m_pend_data; m_sh_dp = m_pend_dp; m_pend_full = 1'b0;
      end
      if (m_xfer) begin
        m_pend_data = frame_data; m_pend_dp = frame_dp; m_pend_full = 1'b1;
      end
      m_t++;
      m_rdy = !m_pend_full;
    end
    q.push_back(model_pins());

    @(negedge clk);
    e = q.pop_front();
    chk("an", 32'(an), 32'(e.an));
    chk("hex", 32'(hex), 32'(e.hex));
    chk("dp", 32'(dp), 32'(e.dp));
    chk("ready", 32'(frame_ready), 32'(e.rdy));
    chk("done", 32'(frame_done), 32'(e.done));
    chk("one_anode_low", 32'($countones(~an) <= 1), 32'd1);

    if (!did_rst) begin
      case (m_t)
        1:  chk("c1_blank", 32'(an), 32'hF);
        2:  begin chk("c2_an", 32'(an), 32'hE); chk("c2_hex", 32'(hex), 32'h0); chk("c2_dp", 32'(dp), 32'd1); end
        6:  chk("c6_not_ready", 32'(frame_ready), 32'd0);
        10: chk("c10_an", 32'(an), 32'hD);
        31: chk("c31_done", 32'(frame_done), 32'd1);
        32: chk("c32_ready", 32'(frame_ready), 32'd1);
        34: begin chk("c34_an", 32'(an), 32'hE); chk("c34_hex", 32'(hex), 32'h4); chk("c34_dp", 32'(dp), 32'd0); end
        58: begin chk("c58_an", 32'(an), 32'h7); chk("c58_hex", 32'(hex), 32'h1); chk("c58_dp", 32'(dp), 32'd1); end
        63: chk("c63_old_shadow", 32'(hex), 32'h1);
        66: chk("c66_hex", 32'(hex), 32'hD);
        106: chk("c106_hex_old", 32'(hex), 32'hC);
        138: begin chk("c138_an", 32'(an), 32'hD); chk("c138_hex", 32'(hex), 32'hF); end
        default: ;
      endcase
    end else if (m_t < 3 * FRAME) begin
      for (int d = 0; d < DIGITS; d++) if (!an[d]) low_cnt[d]++;
      if (an != 4'hF) chk("post_rst_hex_zero", 32'(hex), 32'h0);
      if (frame_done) begin
        if (last_done_t >= 0) chk("done_period", 32'(m_t - last_done_t), 32'(FRAME));
        last_done_t = m_t;
        done_seen++;
      end
    end
  endtask

  task automatic offer(input logic [15:0] d, input logic [3:0] p);
    int n;
    n = 0;
    frame_data  = d;
    frame_dp    = p;
    frame_valid = 1'b1;
    do begin
      step();
      n++;
    end while (!m_xfer && n < 200);
    chk("offer_accepted", 32'(m_xfer), 32'd1);
    frame_valid = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < DIGITS; d++) low_cnt[d] = 0;
    repeat (3) step();
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_ready", 32'(frame_ready), 32'd0);
    rst = 1'b0;

    while (m_t < 5) step();
    offer(16'h1234, 4'b0001);
    offer(16'hABCD, 4'b0000);

    while (m_t < 95) step();
    offer(16'h00F0, 4'b0000);

    while (m_t < 140) step();
    offer(16'h5555, 4'b1111);
    while (m_t < 147) step();
    chk("pre_rst_an", 32'(an), 32'hB);

    rst = 1'b1;
    did_rst = 1'b1;
    step();
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_ready", 32'(frame_ready), 32'd0);
    rst = 1'b0;

    while (m_t < 3 * FRAME + 4) step();
    for (int d = 0; d < DIGITS; d++)
      chk($sformatf("low_cycles_an%0d", d), 32'(low_cnt[d]), 32'(3 * (TDIV - BLANK)));
    chk("done_count", 32'(done_seen), 32'd3);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
